cond_qualifier: RTL

- Upstream condition-generation stage for the logic_reduce output-select register.
- Synchronizes and debounces raw condition inputs and runs an arm/active/cooldown window FSM.
- Drives the clean, registered control signals that logic_reduce consumes: critical, additional_condition1, additional_condition2 and non_critical.
- No combinational path exists from any raw input to any output.

---
 rtl/cond_qualifier.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/cond_qualifier.sv
// Condition qualifier: synchronizes and debounces raw condition inputs and runs the
// arm/active/cooldown window FSM that feeds the logic_reduce output-select register.
module cond_qualifier #(
  parameter int DEBOUNCE = 4,
  parameter int WINDOW   = 8,
  parameter int COOLDOWN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_critical,
  input  logic raw_cond1,
  input  logic raw_cond2,
  input  logic mode_sel,
  input  logic arm,
  input  logic abort,
  output logic critical,
  output logic additional_condition1,
  output logic additional_condition2,
  output logic non_critical,
  output logic window_active,
  output logic window_done
);

  localparam int DW   = $clog2(DEBOUNCE + 1);
  localparam int CMAX = (WINDOW > COOLDOWN) ? WINDOW : COOLDOWN;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [CW-1:0] WIN_LOAD  = CW'(WINDOW - 1);
  localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN - 1);

  typedef enum logic [3:0] {
    ST_IDLE     = 4'b0001,
    ST_ARMED    = 4'b0010,
    ST_ACTIVE   = 4'b0100,
    ST_COOLDOWN = 4'b1000
  } state_t;

  logic [2:0] raw_s;
  logic [2:0] sync1_r;
  logic [2:0] sync2_r;
  logic [2:0] filt_s;
  logic       crit_filt_s;

  assign raw_s = {raw_cond2, raw_cond1, raw_critical};

  // Two-flop synchronizer for every raw channel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 3'b000;
      sync2_r <= 3'b000;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_db
    logic [DW-1:0] cnt_r;
    logic          filt_r;

    // Per-channel debounce: flip only after DEBOUNCE consecutive disagreeing samples
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_r  <= '0;
        filt_r <= 1'b0;
      end else if (sync2_r[g] == filt_r) begin
        cnt_r  <= '0;
        filt_r <= filt_r;
      end else if (cnt_r == DB_LAST) begin
        cnt_r  <= '0;
        filt_r <= ~filt_r;
      end else begin
        cnt_r  <= cnt_r + DW'(1);
        filt_r <= filt_r;
      end
    end

    assign filt_s[g] = filt_r;
  end

  assign crit_filt_s = filt_s[0];

  state_t        state_r, state_nx;
  logic [CW-1:0] cnt_r, cnt_nx;
  logic          mode_r, mode_nx;
  logic          done_r, done_nx;

  // Window FSM state, shared window/cooldown counter, latched mode and done pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= '0;
      mode_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx;
      cnt_r   <= cnt_nx;
      mode_r  <= mode_nx;
      done_r  <= done_nx;
    end
  end

  // Next-state logic; abort overrides every transition including arm
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    mode_nx  = mode_r;
    done_nx  = 1'b0;
    if (abort) begin
      state_nx = ST_IDLE;
      cnt_nx   = '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arm) begin
            state_nx = ST_ARMED;
            mode_nx  = mode_sel;
          end else begin
            state_nx = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (crit_filt_s) begin
            state_nx = ST_ACTIVE;
            cnt_nx   = WIN_LOAD;
          end else begin
            state_nx = ST_ARMED;
          end
        end
        ST_ACTIVE: begin
          // A critical drop beats a coincident window expiry: no done pulse
          if (!crit_filt_s) begin
            state_nx = ST_COOLDOWN;
            cnt_nx   = COOL_LOAD;
          end else if (cnt_r == '0) begin
            state_nx = ST_COOLDOWN;
            cnt_nx   = COOL_LOAD;
            done_nx  = 1'b1;
          end else begin
            cnt_nx   = cnt_r - CW'(1);
          end
        end
        ST_COOLDOWN: begin
          if (cnt_r == '0) begin
            state_nx = ST_IDLE;
          end else begin
            cnt_nx   = cnt_r - CW'(1);
          end
        end
        default: begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  assign critical              = (state_r == ST_ACTIVE);
  assign non_critical          = (state_r == ST_ACTIVE) & mode_r;
  assign window_active         = (state_r == ST_ARMED) | (state_r == ST_ACTIVE);
  assign window_done           = done_r;
  assign additional_condition1 = filt_s[1];
  assign additional_condition2 = filt_s[2];

endmodule
